// File: rtl/sensor_frame_collector.sv
// Collects tagged 8-bit sensor samples over a fixed window and publishes a 5-slot frame with an enable mask.
// Optional: define SENSOR_RANGE_CHECK_EN to reject samples outside MIN_VALID..MAX_VALID.
module sensor_frame_collector #(
  parameter int unsigned WINDOW_CYCLES = 64,
  parameter logic [7:0]  MIN_VALID     = 8'd10,
  parameter logic [7:0]  MAX_VALID     = 8'd40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  input  logic [2:0]  sample_id_i,
  input  logic [7:0]  sample_data_i,
  output logic [39:0] sensors_data_o,
  output logic [4:0]  sensors_en_o,
  output logic        frame_valid_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int unsigned NUM_SENSORS = 5;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned CNT_W       = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

`ifdef SENSOR_RANGE_CHECK_EN
  localparam logic RANGE_BYPASS = 1'b0;
`else
  localparam logic RANGE_BYPASS = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0]          shadow_mask_q, shadow_mask_d, mask_upd;
  logic [NUM_SENSORS*DATA_W-1:0]   shadow_data_q, shadow_data_d, frame_data;
  logic [NUM_SENSORS-1:0]          id_hit;
  logic                            accept, reject, publish, in_range, dup;

  // Next-state, handshake classification and frame assembly
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    shadow_mask_d = '0;
    shadow_data_d = shadow_data_q;
    mask_upd      = shadow_mask_q;
    frame_data    = '0;
    accept        = 1'b0;
    reject        = 1'b0;
    publish       = 1'b0;
    in_range      = RANGE_BYPASS ||
                    ((sample_data_i >= MIN_VALID) && (sample_data_i <= MAX_VALID));
    for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
      id_hit[k] = (sample_id_i == ID_W'(k));
    end
    dup = |(id_hit & shadow_mask_q);

    case (state_q)
      IDLE: begin
        if (enable_i) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          // id_hit is all-zero for ids 5..7, so they fall through to reject
          accept = sample_valid_i && (|id_hit) && !dup && in_range;
          reject = sample_valid_i && !accept;
          if (accept) mask_upd = shadow_mask_q | id_hit;
          for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
            if (accept && id_hit[k]) shadow_data_d[k*DATA_W +: DATA_W] = sample_data_i;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = PUBLISH;
            publish = 1'b1;
          end else begin
            cnt_d         = CNT_W'(cnt_q + 1'b1);
            shadow_mask_d = mask_upd;
          end
        end
      end
      PUBLISH: begin
        state_d = enable_i ? COLLECT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Slots without a valid sample this window publish as zero
    for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
      frame_data[k*DATA_W +: DATA_W] = mask_upd[k] ? shadow_data_d[k*DATA_W +: DATA_W] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Window datapath, published frame and drop counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q          <= '0;
      shadow_mask_q  <= '0;
      shadow_data_q  <= '0;
      sample_ready_o <= 1'b0;
      frame_valid_o  <= 1'b0;
      sensors_data_o <= '0;
      sensors_en_o   <= '0;
      drop_cnt_o     <= '0;
    end else begin
      cnt_q          <= cnt_d;
      shadow_mask_q  <= shadow_mask_d;
      shadow_data_q  <= shadow_data_d;
      sample_ready_o <= (state_d == COLLECT);
      frame_valid_o  <= publish;
      if (publish) begin
        sensors_data_o <= frame_data;
        sensors_en_o   <= mask_upd;
      end
      if (reject && (drop_cnt_o != 8'hFF)) drop_cnt_o <= 8'(drop_cnt_o + 1'b1);
    end
  end

endmodule
